// File: rtl/ks_approx_pkg.sv
// Shared types and helpers for the approximate Kogge-Stone adder pipeline.
// Used by ks_approx_pipe and ks_pg_cell.
package ks_approx_pkg;

   typedef struct packed {
      logic p;
      logic g;
   } pg_t;

   localparam int ERR_CNT_W = 32;

   // Number of Kogge-Stone levels needed to span w bits: ceil(log2(w)).
   function automatic int ks_levels(input int w);
      int lv;
      lv = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < w) lv = i + 1;
      end
      return lv;
   endfunction

endpackage

// File: rtl/ks_pg_cell.sv
// Kogge-Stone black cell: merges a higher (generate, propagate) span with the
// adjacent lower span.
module ks_pg_cell
   import ks_approx_pkg::*;
(
   input  pg_t i_hi,
   input  pg_t i_lo,
   output pg_t o_pg
);

   assign o_pg.g = i_hi.g | (i_hi.p & i_lo.g);
   assign o_pg.p = i_hi.p & i_lo.p;

endmodule

// File: rtl/ks_approx_pipe.sv
// Three-stage approximate adder: the low K bits use local generate only, the
// upper bits use a Kogge-Stone prefix tree. Macro KS_ERR_MON_EN adds an exact-sum error monitor.
module ks_approx_pipe
   import ks_approx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int KW    = $clog2(WIDTH + 1)
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 cin,
   input  logic [KW-1:0]        k,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH:0]       sum,
   output logic                 err_flag,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int          LVLS    = ks_levels(WIDTH);
   localparam logic [31:0] WIDTH_U = 32'(WIDTH);

   // Handshake: a beat moves on an edge where valid&ready; a full stage holds
   // while its successor holds, an empty stage always loads (bubbles collapse).
   logic w_en1, w_en2, w_en3, w_accept;
   logic r_s1_v, r_s2_v, r_s3_v;

   assign in_ready  = !(r_s3_v & !out_ready);
   assign w_accept  = in_valid & in_ready;
   assign w_en3     = !r_s3_v | out_ready;
   assign w_en2     = !r_s2_v | w_en3;
   assign w_en1     = !r_s1_v | w_en2;

   // ---------------- Stage 1: p/g, clamped k, cin ----------------
   logic [WIDTH-1:0] r_s1_p, r_s1_g;
   logic [KW-1:0]    r_s1_k;
   logic             r_s1_cin;
   logic [KW-1:0]    w_k_clamp;

   always_comb begin
      w_k_clamp = k;
      if (32'(k) > WIDTH_U) w_k_clamp = KW'(WIDTH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n)     r_s1_v <= 1'b0;
      else if (w_en1) r_s1_v <= w_accept;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_p   <= a ^ b;
         r_s1_g   <= a & b;
         r_s1_k   <= w_k_clamp;
         r_s1_cin <= cin;
      end
   end

   // ---------------- Prefix tree between S1 and S2 ----------------
   // Bits below K-1 are killed and bit K-1 becomes a pure generator, so a
   // plain prefix from bit 0 yields G[j:K] | P[j:K] & c(K-1) for j >= K.
   logic [31:0]      w_k32;
   pg_t [WIDTH-1:0]  w_mod;
   pg_t [WIDTH-1:0]  w_pref;
   logic [WIDTH-1:0] w_carry;
   logic [WIDTH-1:0] w_pref_p;
   logic             w_unused_p;

   assign w_k32 = 32'(r_s1_k);

   always_comb begin
      w_mod = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         if (j >= w_k32) begin
            w_mod[j].p = r_s1_p[j];
            w_mod[j].g = r_s1_g[j];
         end else if (j + 1 == w_k32) begin
            w_mod[j].g = r_s1_g[j];
         end
      end
      if (w_k32 == 32'd0) w_mod[0].g = r_s1_g[0] | (r_s1_p[0] & r_s1_cin);
   end

   for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
      pg_t [WIDTH-1:0] w_pg;
      if (l == 0) begin : g_leaf
         assign w_pg = w_mod;
      end else begin : g_node
         for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            if (j >= (1 << (l - 1))) begin : g_cell
               ks_pg_cell u_cell (
                  .i_hi (g_lvl[l-1].w_pg[j]),
                  .i_lo (g_lvl[l-1].w_pg[j-(1<<(l-1))]),
                  .o_pg (w_pg[j])
               );
            end else begin : g_pass
               assign w_pg[j] = g_lvl[l-1].w_pg[j];
            end
         end
      end
   end

   assign w_pref = g_lvl[LVLS].w_pg;

   always_comb begin
      w_carry  = '0;
      w_pref_p = '0;
      for (int unsigned j = 0; j < WIDTH; j++) begin
         w_carry[j]  = (j < w_k32) ? r_s1_g[j] : w_pref[j].g;
         w_pref_p[j] = w_pref[j].p;
      end
   end

   assign w_unused_p = ^w_pref_p;

   // ---------------- Stage 2: carries ----------------
   logic [WIDTH-1:0] r_s2_c, r_s2_p;
   logic             r_s2_c0;

   always_ff @(posedge clk) begin
      if (!rst_n)     r_s2_v <= 1'b0;
      else if (w_en2) r_s2_v <= r_s1_v;
   end

   always_ff @(posedge clk) begin
      if (w_en2 && r_s1_v) begin
         r_s2_c  <= w_carry;
         r_s2_p  <= r_s1_p;
         r_s2_c0 <= (w_k32 == 32'd0) & r_s1_cin;
      end
   end

   // ---------------- Stage 3: sum ----------------
   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] r_s3_sum;

   assign w_sum = {r_s2_c[WIDTH-1], r_s2_p ^ {r_s2_c[WIDTH-2:0], r_s2_c0}};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s3_v   <= 1'b0;
         r_s3_sum <= '0;
      end else if (w_en3) begin
         r_s3_v <= r_s2_v;
         if (r_s2_v) r_s3_sum <= w_sum;
      end
   end

   assign out_valid = r_s3_v;
   assign sum       = r_s3_sum;

`ifdef KS_ERR_MON_EN
   logic [WIDTH:0]         r_s1_exact, r_s2_exact;
   logic                   r_s3_err;
   logic [ERR_CNT_W-1:0]   r_err_cnt;

   always_ff @(posedge clk) begin
      if (w_accept) r_s1_exact <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      if (w_en2 && r_s1_v) r_s2_exact <= r_s1_exact;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s3_err  <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         if (w_en3 && r_s2_v) r_s3_err <= (w_sum != r_s2_exact);
         if (r_s3_v && out_ready && r_s3_err && (r_err_cnt != '1))
            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
   end

   assign err_flag = r_s3_v & r_s3_err;
   assign err_cnt  = r_err_cnt;
`else
   assign err_flag = 1'b0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_ks_approx_pipe.sv
// Bench for ks_approx_pipe: hand-derived vector table, stall/reset sequences
// and a random run, all checked through an expected-result queue.
module tb_ks_approx_pipe;

   localparam int W  = 16;
   localparam int KW = 5;
`ifdef KS_ERR_MON_EN
   localparam bit MON = 1'b1;
`else
   localparam bit MON = 1'b0;
`endif

   logic          clk, rst_n;
   logic          in_valid, in_ready;
   logic [W-1:0]  a, b;
   logic          cin;
   logic [KW-1:0] k;
   logic          out_valid, out_ready;
   logic [W:0]    sum;
   logic          err_flag;
   logic [31:0]   err_cnt;

   ks_approx_pipe #(.WIDTH(W), .KW(KW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .k         (k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .err_flag  (err_flag),
      .err_cnt   (err_cnt)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1);
   end

   // ---------------- vectors and model ----------------
   typedef struct {
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic          cin;
      logic [KW-1:0] k;
      logic [W:0]    sum;
      logic          err;
   } vec_t;

   vec_t vecs [10];

   function automatic vec_t mk(input logic [W-1:0] va, vb, input logic vc,
                               input logic [KW-1:0] vk, input logic [W:0] vs,
                               input logic ve);
      vec_t v;
      v.a = va; v.b = vb; v.cin = vc; v.k = vk; v.sum = vs; v.err = ve;
      return v;
   endfunction

   // Ripple form of the approximate rule: low K carries are local generates,
   // upper carries ripple from c(K-1) (cin when K is zero).
   function automatic logic [W:0] model(input logic [W-1:0] ma, mb, input logic mc,
                                        input int mk_in);
      int           kk;
      logic [W-1:0] p, g, c;
      logic [W:0]   s;
      logic         cprev;
      kk = (mk_in > W) ? W : mk_in;
      p  = ma ^ mb;
      g  = ma & mb;
      c  = '0;
      for (int j = 0; j < W; j++) begin
         if (j < kk) begin
            c[j] = g[j];
         end else begin
            if (j == 0) cprev = mc;
            else        cprev = c[j-1];
            c[j] = g[j] | (p[j] & cprev);
         end
      end
      s[0] = p[0] ^ ((kk == 0) ? mc : 1'b0);
      for (int j = 1; j < W; j++) s[j] = p[j] ^ c[j-1];
      s[W] = c[W-1];
      return s;
   endfunction

   function automatic vec_t mk_model(input logic [W-1:0] va, vb, input logic vc,
                                     input logic [KW-1:0] vk);
      logic [W:0] approx, exact;
      approx = model(va, vb, vc, int'(vk));
      exact  = {1'b0, va} + {1'b0, vb} + {{W{1'b0}}, vc};
      return mk(va, vb, vc, vk, approx, approx != exact);
   endfunction

   // ---------------- scoreboard ----------------
   logic [W+1:0] exp_q [$];
   logic [W+1:0] mon_e;
   int           n_tests = 0;
   int           n_fail = 0;
   int           exp_err_cnt = 0;
   bit           rand_ready = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got sum 0x%0h, expected no result", sum);
         end else begin
            mon_e = exp_q.pop_front();
            check("sum", 64'(sum), 64'(mon_e[W:0]));
            check("err_flag", 64'(err_flag), 64'(MON & mon_e[W+1]));
            if (mon_e[W+1]) exp_err_cnt++;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- driver tasks ----------------
   // Called and returns at posedge + 1.
   task automatic drive_beat(input vec_t v);
      int n;
      n = 0;
      in_valid = 1'b1;
      a = v.a; b = v.b; cin = v.cin; k = v.k;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back({v.err, v.sum});
            @(posedge clk); #1;
            in_valid = 1'b0;
            break;
         end
         n++;
         if (n > 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected accept", n);
            in_valid = 1'b0;
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int   acc;
      vec_t sv [4];
      vec_t rv;

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; k = '0;
      out_ready = 1'b1;

      vecs[0] = mk(16'h003F, 16'h0001, 1'b0, 5'd6,  17'h0003C, 1'b1);
      vecs[1] = mk(16'hFFFF, 16'h0001, 1'b0, 5'd0,  17'h10000, 1'b0);
      vecs[2] = mk(16'hFFFF, 16'h0001, 1'b0, 5'd6,  17'h0FFFC, 1'b1);
      vecs[3] = mk(16'h1234, 16'h0FFF, 1'b1, 5'd0,  17'h02234, 1'b0);
      vecs[4] = mk(16'h1234, 16'h0FFF, 1'b1, 5'd20, 17'h019A3, 1'b1);
      vecs[5] = mk(16'h1234, 16'h0FFF, 1'b1, 5'd16, 17'h019A3, 1'b1);
      vecs[6] = mk(16'hFFFF, 16'hFFFF, 1'b1, 5'd16, 17'h1FFFE, 1'b1);
      vecs[7] = mk(16'h0001, 16'h0001, 1'b1, 5'd1,  17'h00002, 1'b1);
      vecs[8] = mk(16'h00F0, 16'h0010, 1'b0, 5'd4,  17'h00100, 1'b0);
      vecs[9] = mk(16'h0000, 16'h0000, 1'b1, 5'd0,  17'h00001, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_sum",       64'(sum),       64'd0);
      check("reset_err_flag",  64'(err_flag),  64'd0);
      check("reset_err_cnt",   64'(err_cnt),   64'd0);
      check("reset_in_ready",  64'(in_ready),  64'd1);

      // Latency: accepted at edge n, visible before edge n+3.
      drive_beat(vecs[0]);
      @(negedge clk); check("lat_after_n",   64'(out_valid), 64'd0);
      @(negedge clk); check("lat_after_n1",  64'(out_valid), 64'd0);
      @(negedge clk); check("lat_after_n2",  64'(out_valid), 64'd1);
      @(posedge clk); #1;

      for (int i = 1; i < 10; i++) drive_beat(vecs[i]);
      wait_drain();
      check("err_cnt_table", 64'(err_cnt), MON ? 64'(exp_err_cnt) : 64'd0);

      // Stall: four beats offered while the output is blocked for six cycles.
      for (int i = 0; i < 4; i++)
         sv[i] = mk_model(16'h00FF + 16'(i) * 16'h1111, 16'h0F0F, i[0], 5'(i * 3));
      out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         if (acc < 4) begin
            in_valid = 1'b1;
            a = sv[acc].a; b = sv[acc].b; cin = sv[acc].cin; k = sv[acc].k;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back({sv[acc].err, sv[acc].sum});
            acc++;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      check("stall_accepts",   64'(acc),       64'd3);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      if (acc < 4) drive_beat(sv[acc]);
      wait_drain();

      // Reset with two beats in flight.
      drive_beat(mk_model(16'hFFFF, 16'h0001, 1'b0, 5'd6));
      drive_beat(mk_model(16'h0FFF, 16'h0001, 1'b0, 5'd3));
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_err_cnt = 0;
      check("rst_mid_out_valid", 64'(out_valid), 64'd0);
      check("rst_mid_err_cnt",   64'(err_cnt),   64'd0);
      check("rst_mid_in_ready",  64'(in_ready),  64'd1);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("no_stale", 64'(out_valid), 64'd0);
      end
      @(posedge clk); #1;

      // Random beats with random k and random back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         rv = mk_model(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
         drive_beat(rv);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_ready = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      check("err_cnt_random", 64'(err_cnt), MON ? 64'(exp_err_cnt) : 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ks_approx_pipe.md
KS_APPROX_PIPE -- requirements
Module: ks_approx_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (4..64).
REQ-002 SHALL have parameter KW, default $clog2(WIDTH+1), width of the k port.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, operand beat valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts a beat this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH each, operands.
REQ-008 SHALL have port cin, input, 1, carry-in.
REQ-009 SHALL have port k, input, KW, approximated low-bit count, sampled with the beat.
REQ-010 SHALL have port out_valid, output, 1, result valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-012 SHALL have port sum, output, WIDTH+1, result; MSB is the final carry.
REQ-013 SHALL have ports err_flag (1) and err_cnt (32), outputs, error monitor (see Configuration).

Function
REQ-014 SHALL use p_j=a_j^b_j, g_j=a_j&b_j for bits j=0..WIDTH-1.
REQ-015 For j<K, SHALL set c_j=g_j (no propagation); K=min(k,WIDTH).
REQ-016 For j>=K, SHALL set c_j=G[j:K] | (P[j:K] & c_(K-1)), with c_(-1)=cin; K=0 gives the exact sum.
REQ-017 SHALL ignore cin when K>0; sum_0=p_0 when K>0, else p_0^cin.
REQ-018 SHALL set sum_j=p_j^c_(j-1) for j>=1 and sum[WIDTH]=c_(WIDTH-1).
REQ-019 SHALL compute the G/P spans for j>=K with a Kogge-Stone prefix tree of ceil(log2 WIDTH) levels.
REQ-020 SHALL be 3 stages: S1 registers p/g/k/cin; S2 registers prefix carries; S3 registers sum.
REQ-021 SHALL present a beat accepted at edge n as out_valid at edge n+3 when no stall occurs.
REQ-022 SHALL sustain one beat per cycle while out_ready=1.
REQ-023 SHALL accept a beat only when in_valid&in_ready and complete a result only when out_valid&out_ready.
REQ-024 SHALL hold all stages, including sum, while out_valid=1 and out_ready=0.
REQ-025 SHALL drive in_ready=!(out_valid&!out_ready) and make it purely combinational from S3 state and out_ready.
REQ-026 SHALL let bubbles advance; an empty stage is overwritten even during a downstream stall.
REQ-027 SHALL clamp k values above WIDTH to WIDTH.

Reset
REQ-028 On rst_n=0 at a clock edge, SHALL clear all stage valids, sum to 0, err_flag to 0 and err_cnt to 0.
REQ-029 SHALL discard in-flight beats on a mid-operation reset; no result from them appears after reset.
REQ-030 SHALL drive in_ready=1 in the first cycle after reset release.

Configuration
REQ-031 With macro KS_ERR_MON_EN defined, SHALL carry an exact (K=0) sum alongside each beat.
REQ-032 With KS_ERR_MON_EN defined, SHALL set err_flag=1 with out_valid when sum differs from the exact sum.
REQ-033 With KS_ERR_MON_EN defined, SHALL increment err_cnt on each completed erroneous result and saturate at 0xFFFFFFFF.
REQ-034 Without KS_ERR_MON_EN, SHALL keep the ports, tie err_flag and err_cnt to 0, and instantiate no exact-adder logic.

Structure
REQ-035 SHALL place the pg_t struct {p,g}, the ERR_CNT_W=32 constant and the prefix-level count function in shared package ks_approx_pkg.
REQ-036 SHALL implement the prefix black cell (G=Gh|Ph&Gl, P=Ph&Pl) as sub-module ks_pg_cell.

Verification
REQ-037 Bench SHALL check: WIDTH=16, k=6, a=0x003F, b=0x0001, cin=0 -> sum=0x0003C three cycles later; err_flag=1 with the monitor enabled.
REQ-038 Bench SHALL check: k=0, a=0xFFFF, b=0x0001, cin=0 -> sum=0x10000; with k=6 -> sum=0x0FFFC.
REQ-039 Bench SHALL check: k=0, a=0x1234, b=0x0FFF, cin=1 -> sum=0x02234, err_flag=0; with k=20 -> treated as k=16.
REQ-040 Bench SHALL check: 4 back-to-back beats with out_ready=0 for 6 cycles -> in_ready falls after 3 accepts, no beat is lost, results emerge in order once out_ready=1.
REQ-041 Bench SHALL check: rst_n=0 for one cycle while 2 beats are in flight -> out_valid=0, err_cnt=0, and no stale result appears.
REQ-042 Bench SHALL check: 10000 random beats with random k and random out_ready -> each sum matches the REQ-015..018 model, and err_cnt equals the model mismatch count.
